// File: rtl/cic_comb_chain.sv
// cic_comb_chain: cascade of registered comb stages (x[n] - x[n-M]) for time-multiplexed
// channels, with per-stage wrap or clamp and overflow reporting.
module cic_comb_chain #(
   parameter int WIDTH    = 16,
   parameter int N_DELAYS = 1,
   parameter int N_STAGES = 3,
   parameter int N_CH     = 1,
   parameter bit SATURATE = 1'b0,
   localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CW-1:0]    in_ch,
   input  logic             clr_sticky,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    out_ch,
   output logic             overflow,
   output logic             ovf_sticky
);
   localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
   localparam int NV = 2 ** CW;
   // one bit per encodable channel index, set only for channels that exist
   localparam logic [NV-1:0] CH_OK = {NV{1'b1}} >> (NV - N_CH);

   logic ovf_sticky_q, ovf_sticky_d;

   for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
      logic             iv, io, ovf, vld_q, vld_d, ovr_q, ovr_d;
      logic [WIDTH-1:0] ix, res, dat_q, dat_d;
      logic [CW-1:0]    ic, ch_q, ch_d;
      logic [WIDTH:0]   diff;
      logic [WIDTH-1:0] dly_q [N_CH][N_DELAYS];
      logic [WIDTH-1:0] dly_d [N_CH][N_DELAYS];
      if (s == 0) begin : g_src
         assign iv = in_valid & CH_OK[in_ch];
         assign ix = in_data;
         assign ic = in_ch;
         assign io = 1'b0;
      end else begin : g_src
         assign iv = g_stage[s-1].vld_q;
         assign ix = g_stage[s-1].dat_q;
         assign ic = g_stage[s-1].ch_q;
         assign io = g_stage[s-1].ovr_q;
      end
      always_comb begin
         diff  = {ix[WIDTH-1], ix} - {dly_q[ic][N_DELAYS-1][WIDTH-1], dly_q[ic][N_DELAYS-1]};
         ovf   = diff[WIDTH] ^ diff[WIDTH-1];
         res   = (ovf && SATURATE) ? (diff[WIDTH] ? MIN_V : MAX_V) : diff[WIDTH-1:0];
         dly_d = dly_q;
         if (iv) begin
            dly_d[ic][0] = ix;
            for (int j = 1; j < N_DELAYS; j++) dly_d[ic][j] = dly_q[ic][j-1];
         end
         vld_d = iv;
         ovr_d = iv & (io | ovf);
         dat_d = iv ? res : dat_q;
         ch_d  = iv ? ic : ch_q;
      end
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
            dat_q <= '0;
            ch_q  <= '0;
            dly_q <= '{default: '0};
         end else begin
            vld_q <= vld_d;
            ovr_q <= ovr_d;
            dat_q <= dat_d;
            ch_q  <= ch_d;
            dly_q <= dly_d;
         end
      end
   end

   assign out_valid  = g_stage[N_STAGES-1].vld_q;
   assign out_data   = g_stage[N_STAGES-1].dat_q;
   assign out_ch     = g_stage[N_STAGES-1].ch_q;
   assign overflow   = g_stage[N_STAGES-1].ovr_q;
   assign ovf_sticky = ovf_sticky_q;

   // a new overflow wins over a coincident clear
   always_comb ovf_sticky_d = (out_valid & overflow) | (ovf_sticky_q & ~clr_sticky);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ovf_sticky_q <= 1'b0;
      else       ovf_sticky_q <= ovf_sticky_d;
   end
endmodule

// File: tb/tb_cic_comb_chain.sv
// tb_cic_comb_chain: scoreboard bench over several parameterisations of the comb chain.
module tb_cic_comb_chain;
   typedef struct packed {
      logic [31:0] t;
      logic [7:0]  d;
      logic [1:0]  c;
      logic        f;
   } exp_t;

   logic        clk = 1'b0, rstn = 1'b1, clr = 1'b0;
   logic [31:0] cyc = 0;
   int          total = 0, bad = 0;
   exp_t        sb [5][$];

   logic       ab_v = 1'b0, c_v = 1'b0, d_v = 1'b0, e_v = 1'b0;
   logic [7:0] ab_d = '0, c_d = '0, d_d = '0, e_d = '0;
   logic [1:0] ab_c = '0;

   logic       a_ov, b_ov, c_ov, d_ov, e_ov;
   logic [7:0] a_od, b_od, c_od, d_od, e_od;
   logic [1:0] a_oc, b_oc;
   logic       c_oc, d_oc, e_oc;
   logic       a_of, b_of, c_of, d_of, e_of;
   logic       a_st, b_st, c_st, d_st, e_st;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cic_comb_chain #(.WIDTH(8), .N_DELAYS(1), .N_STAGES(1), .N_CH(3), .SATURATE(1'b0)) u_a (
      .clk(clk), .rstn(rstn), .in_valid(ab_v), .in_data(ab_d), .in_ch(ab_c), .clr_sticky(clr),
      .out_valid(a_ov), .out_data(a_od), .out_ch(a_oc), .overflow(a_of), .ovf_sticky(a_st));
   cic_comb_chain #(.WIDTH(8), .N_DELAYS(1), .N_STAGES(1), .N_CH(3), .SATURATE(1'b1)) u_b (
      .clk(clk), .rstn(rstn), .in_valid(ab_v), .in_data(ab_d), .in_ch(ab_c), .clr_sticky(clr),
      .out_valid(b_ov), .out_data(b_od), .out_ch(b_oc), .overflow(b_of), .ovf_sticky(b_st));
   cic_comb_chain #(.WIDTH(8), .N_DELAYS(2), .N_STAGES(1), .N_CH(1), .SATURATE(1'b0)) u_c (
      .clk(clk), .rstn(rstn), .in_valid(c_v), .in_data(c_d), .in_ch(1'b0), .clr_sticky(clr),
      .out_valid(c_ov), .out_data(c_od), .out_ch(c_oc), .overflow(c_of), .ovf_sticky(c_st));
   cic_comb_chain #(.WIDTH(8), .N_DELAYS(1), .N_STAGES(2), .N_CH(1), .SATURATE(1'b0)) u_d (
      .clk(clk), .rstn(rstn), .in_valid(d_v), .in_data(d_d), .in_ch(1'b0), .clr_sticky(clr),
      .out_valid(d_ov), .out_data(d_od), .out_ch(d_oc), .overflow(d_of), .ovf_sticky(d_st));
   cic_comb_chain #(.WIDTH(8), .N_DELAYS(1), .N_STAGES(3), .N_CH(1), .SATURATE(1'b0)) u_e (
      .clk(clk), .rstn(rstn), .in_valid(e_v), .in_data(e_d), .in_ch(1'b0), .clr_sticky(clr),
      .out_valid(e_ov), .out_data(e_od), .out_ch(e_oc), .overflow(e_of), .ovf_sticky(e_st));

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic mon(input int i, input logic v, input logic [7:0] d, input logic [1:0] c, input logic f);
      exp_t e;
      if (!v) check($sformatf("idle_ovf%0d", i), 32'(f), 32'd0);
      else if (sb[i].size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_out%0d: got data %0h ch %0d at cycle %0d, expected no output", i, d, c, cyc);
      end else begin
         e = sb[i].pop_front();
         check($sformatf("out%0d_cycle", i), cyc, e.t);
         check($sformatf("out%0d_data", i), 32'(d), 32'(e.d));
         check($sformatf("out%0d_ch", i), 32'(c), 32'(e.c));
         check($sformatf("out%0d_ovf", i), 32'(f), 32'(e.f));
      end
   endtask

   always @(negedge clk) begin
      mon(0, a_ov, a_od, a_oc, a_of);
      mon(1, b_ov, b_od, b_oc, b_of);
      mon(2, c_ov, c_od, {1'b0, c_oc}, c_of);
      mon(3, d_ov, d_od, {1'b0, d_oc}, d_of);
      mon(4, e_ov, e_od, {1'b0, e_oc}, e_of);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ab(input logic v, input logic [7:0] d, input logic [1:0] c,
                     input logic [7:0] ea, input logic [7:0] eb, input logic f, input logic ex);
      ab_v = v; ab_d = d; ab_c = c;
      if (ex) begin
         sb[0].push_back('{cyc + 1, ea, c, f});
         sb[1].push_back('{cyc + 1, eb, c, f});
      end
      tick();
   endtask

   task automatic cc(input logic v, input logic [7:0] d, input logic [7:0] e);
      c_v = v; c_d = d;
      if (v) sb[2].push_back('{cyc + 1, e, 2'd0, 1'b0});
      tick();
   endtask

   task automatic dd(input logic v, input logic [7:0] d, input logic [7:0] e);
      d_v = v; d_d = d;
      if (v) sb[3].push_back('{cyc + 2, e, 2'd0, 1'b0});
      tick();
   endtask

   task automatic ee(input logic v, input logic [7:0] d, input logic [7:0] e, input logic ex);
      e_v = v; e_d = d;
      if (ex) sb[4].push_back('{cyc + 3, e, 2'd0, 1'b0});
      tick();
   endtask

   initial begin
      #1 rstn = 1'b0;
      #2;
      check("rst_valid_ovf_sticky", {a_ov, b_ov, c_ov, d_ov, e_ov, a_of, b_of, c_of, d_of, e_of,
                                     a_st, b_st, c_st, d_st, e_st}, 32'd0);
      check("rst_data", {a_od, b_od, c_od, d_od}, 32'd0);
      check("rst_data_ch", {e_od, a_oc, b_oc, c_oc, d_oc, e_oc}, 32'd0);
      repeat (2) tick();
      rstn = 1'b1;
      ab(1'b1, 8'd10,  2'd0, 8'd10,  8'd10,  1'b0, 1'b1);
      ab(1'b1, 8'd100, 2'd1, 8'd100, 8'd100, 1'b0, 1'b1);
      ab(1'b1, 8'd12,  2'd0, 8'd2,   8'd2,   1'b0, 1'b1);
      ab(1'b1, 8'd90,  2'd1, 8'hF6,  8'hF6,  1'b0, 1'b1);
      ab(1'b1, 8'd127, 2'd2, 8'd127, 8'd127, 1'b0, 1'b1);
      ab(1'b1, 8'h80,  2'd2, 8'h01,  8'h80,  1'b1, 1'b1);
      check("sticky_pre", {a_st, b_st}, 32'd0);
      ab(1'b1, 8'd127, 2'd2, 8'hFF,  8'h7F,  1'b1, 1'b1);
      check("sticky_set", {a_st, b_st}, 32'd3);
      clr = 1'b1;
      ab(1'b0, 8'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      check("sticky_clr_vs_set", {a_st, b_st}, 32'd3);
      ab(1'b0, 8'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      check("sticky_clr", {a_st, b_st}, 32'd0);
      clr = 1'b0;
      ab(1'b1, 8'd55,  2'd3, 8'd0,  8'd0,  1'b0, 1'b0);
      ab(1'b1, 8'd20,  2'd0, 8'd8,  8'd8,  1'b0, 1'b1);
      ab(1'b1, 8'h80,  2'd1, 8'h26, 8'h80, 1'b1, 1'b1);
      ab(1'b0, 8'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      ab(1'b0, 8'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1'b0);
      check("sticky_after_clr_ovf", {a_st, b_st}, 32'd3);
      cc(1'b1, 8'd1, 8'd1);
      cc(1'b0, 8'd0, 8'd0);
      cc(1'b1, 8'd2, 8'd2);
      cc(1'b0, 8'd0, 8'd0);
      cc(1'b1, 8'd4, 8'd3);
      cc(1'b1, 8'd7, 8'd5);
      cc(1'b0, 8'd0, 8'd0);
      dd(1'b1, 8'd5, 8'd5);
      dd(1'b1, 8'd5, 8'hFB);
      for (int i = 0; i < 4; i++) dd(1'b1, 8'd5, 8'd0);
      for (int i = 0; i < 3; i++) dd(1'b0, 8'd0, 8'd0);
      ee(1'b1, 8'd50, 8'd0, 1'b0);
      ee(1'b1, 8'd60, 8'd0, 1'b0);
      e_v = 1'b0;
      rstn = 1'b0;
      #1;
      check("rst_mid_async", {e_ov, e_od, e_of, e_st, a_st}, 32'd0);
      tick();
      rstn = 1'b1;
      ee(1'b1, 8'd9, 8'd9, 1'b1);
      ee(1'b1, 8'd9, 8'hEE, 1'b1);
      ee(1'b1, 8'd9, 8'd9, 1'b1);
      ee(1'b1, 8'd9, 8'd0, 1'b1);
      ee(1'b1, 8'd9, 8'd0, 1'b1);
      for (int i = 0; i < 5; i++) ee(1'b0, 8'd0, 8'd0, 1'b0);
      for (int i = 0; i < 5; i++) check($sformatf("drain%0d", i), 32'(sb[i].size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
